// File: rtl/vga_text_timing_if.sv
// Pixel fetch bus (pa/ca out, p back) and VGA pin bundle of vga_text_timing.
interface vga_text_timing_if #(
    parameter int PA_W = 7,
    parameter int CA_W = 11
);
    logic [7:0]      p;
    logic [PA_W-1:0] pa;
    logic [CA_W-1:0] ca;
    logic [2:0]      vga_red;
    logic [2:0]      vga_grn;
    logic [1:0]      vga_blu;
    logic            vga_hsync;
    logic            vga_vsync;
    logic            vga_de;

    modport master (
        input  p,
        output pa, ca, vga_red, vga_grn, vga_blu, vga_hsync, vga_vsync, vga_de
    );

    modport slave (
        output p,
        input  pa, ca, vga_red, vga_grn, vga_blu, vga_hsync, vga_vsync, vga_de
    );
endinterface

// File: rtl/vga_text_timing.sv
// Parametrised VGA text-mode timing: sync/de generation, glyph addressing, fetch-latency alignment.
// Optional blinking block cursor is compiled in with `define VGA_CURSOR_EN.
module vga_text_timing #(
    parameter int H_ACTIVE     = 640,
    parameter int H_FP         = 16,
    parameter int H_SYNC       = 96,
    parameter int H_BP         = 48,
    parameter int V_ACTIVE     = 350,
    parameter int V_FP         = 37,
    parameter int V_SYNC       = 2,
    parameter int V_BP         = 60,
    parameter bit HSYNC_POL    = 1'b0,
    parameter bit VSYNC_POL    = 1'b0,
    parameter int CHAR_W       = 8,
    parameter int CHAR_H       = 14,
    parameter int COLS         = 80,
    parameter int ROWS         = 25,
    parameter int FETCH_LAT    = 1,
    parameter int BLINK_FRAMES = 16,
    localparam int PA_W = $clog2(CHAR_W*CHAR_H),
    localparam int CA_W = $clog2(COLS*ROWS),
    localparam int CX_W = $clog2(COLS),
    localparam int CY_W = $clog2(ROWS)
) (
    input  logic             vga_clk,
    input  logic             vga_rst_n,
    vga_text_timing_if.master bus,
    output logic             frame_start
`ifdef VGA_CURSOR_EN
    ,
    input  logic [CX_W-1:0]  cursor_x,
    input  logic [CY_W-1:0]  cursor_y,
    input  logic             cursor_on
`endif
);
    localparam int H_TOTAL = H_SYNC + H_BP + H_ACTIVE + H_FP;
    localparam int V_TOTAL = V_SYNC + V_BP + V_ACTIVE + V_FP;
    localparam int HC_W    = $clog2(H_TOTAL);
    localparam int VC_W    = $clog2(V_TOTAL);
    localparam int PX_W    = (CHAR_W > 1) ? $clog2(CHAR_W) : 1;
    localparam int PY_W    = (CHAR_H > 1) ? $clog2(CHAR_H) : 1;
    localparam int STAGES  = FETCH_LAT + 1;

    localparam logic [HC_W-1:0] HS_END = HC_W'(H_SYNC);
    localparam logic [HC_W-1:0] HA_BEG = HC_W'(H_SYNC + H_BP);
    localparam logic [HC_W-1:0] HA_END = HC_W'(H_SYNC + H_BP + H_ACTIVE);
    localparam logic [VC_W-1:0] VS_END = VC_W'(V_SYNC);
    localparam logic [VC_W-1:0] VA_BEG = VC_W'(V_SYNC + V_BP);
    localparam logic [VC_W-1:0] VA_END = VC_W'(V_SYNC + V_BP + V_ACTIVE);

    if (H_ACTIVE != COLS*CHAR_W || V_ACTIVE != ROWS*CHAR_H) begin : g_geom_chk
        $error("vga_text_timing: active area must equal the character grid");
    end
    if (FETCH_LAT < 0 || FETCH_LAT > 4 || BLINK_FRAMES < 1) begin : g_par_chk
        $error("vga_text_timing: FETCH_LAT must be 0..4 and BLINK_FRAMES >= 1");
    end

    logic [HC_W-1:0] hc;
    logic [VC_W-1:0] vc;
    logic [PX_W-1:0] px;
    logic [PY_W-1:0] py;
    logic [CX_W-1:0] cx;
    logic [CY_W-1:0] cy;
    logic [PA_W-1:0] pbase;
    logic [CA_W-1:0] rbase;
    logic            h_act, v_act, act, h_last, v_last, line_end, px_last, py_last;
    logic            cur_hit;
    logic [7:0]      col, pix;
    logic [STAGES:0] de_pipe, hs_pipe, vs_pipe;

    assign h_act    = (hc >= HA_BEG) && (hc < HA_END);
    assign v_act    = (vc >= VA_BEG) && (vc < VA_END);
    assign act      = h_act && v_act;
    assign h_last   = hc == HC_W'(H_TOTAL - 1);
    assign v_last   = vc == VC_W'(V_TOTAL - 1);
    assign px_last  = px == PX_W'(CHAR_W - 1);
    assign py_last  = py == PY_W'(CHAR_H - 1);
    assign line_end = v_act && (hc == HC_W'(H_SYNC + H_BP + H_ACTIVE - 1));

    // hc/vc name the position being emitted by the next edge
    always_ff @(posedge vga_clk or negedge vga_rst_n) begin
        if (!vga_rst_n) begin
            hc <= '0;
            vc <= '0;
        end else begin
            hc <= h_last ? '0 : hc + 1'b1;
            if (h_last) vc <= v_last ? '0 : vc + 1'b1;
        end
    end

    // Cell walk with running row bases, so addresses need no multiply or divide
    always_ff @(posedge vga_clk or negedge vga_rst_n) begin
        if (!vga_rst_n) begin
            px <= '0; cx <= '0; py <= '0; cy <= '0; pbase <= '0; rbase <= '0;
        end else begin
            if (!h_act) begin
                px <= '0;
                cx <= '0;
            end else if (px_last) begin
                px <= '0;
                cx <= cx + 1'b1;
            end else begin
                px <= px + 1'b1;
            end
            if (!v_act) begin
                py <= '0; cy <= '0; pbase <= '0; rbase <= '0;
            end else if (line_end) begin
                if (py_last) begin
                    py    <= '0;
                    pbase <= '0;
                    cy    <= cy + 1'b1;
                    rbase <= rbase + CA_W'(COLS);
                end else begin
                    py    <= py + 1'b1;
                    pbase <= pbase + PA_W'(CHAR_W);
                end
            end
        end
    end

`ifdef VGA_CURSOR_EN
    localparam int FC_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    logic [CX_W-1:0]   cur_x;
    logic [CY_W-1:0]   cur_y;
    logic              cur_en, blink_vis;
    logic [FC_W-1:0]   fcnt;
    logic [STAGES-1:0] cur_pipe;

    // Cursor inputs are latched once per frame so a mid-frame move cannot tear
    always_ff @(posedge vga_clk or negedge vga_rst_n) begin
        if (!vga_rst_n) begin
            cur_x <= '0; cur_y <= '0; cur_en <= 1'b0;
            blink_vis <= 1'b1; fcnt <= '0; cur_pipe <= '0;
        end else begin
            if (hc == '0 && vc == '0) begin
                cur_x  <= cursor_x;
                cur_y  <= cursor_y;
                cur_en <= cursor_on;
            end
            if (h_last && v_last) begin
                if (fcnt == FC_W'(BLINK_FRAMES - 1)) begin
                    fcnt      <= '0;
                    blink_vis <= ~blink_vis;
                end else begin
                    fcnt <= fcnt + 1'b1;
                end
            end
            cur_pipe <= STAGES'({cur_pipe, cur_hit});
        end
    end

    assign cur_hit = blink_vis && cur_en && act && (cx == cur_x) && (cy == cur_y)
                     && (py >= PY_W'(CHAR_H - 2));
    assign pix     = cur_pipe[STAGES-1] ? ~bus.p : bus.p;
`else
    assign cur_hit = 1'b0;
    assign pix     = bus.p;
`endif

    // Address stage plus FETCH_LAT+1 deep sync/de delay to meet the returning pixel
    always_ff @(posedge vga_clk or negedge vga_rst_n) begin
        if (!vga_rst_n) begin
            bus.pa      <= '0;
            bus.ca      <= '0;
            frame_start <= 1'b0;
            de_pipe     <= '0;
            hs_pipe     <= {(STAGES+1){~HSYNC_POL}};
            vs_pipe     <= {(STAGES+1){~VSYNC_POL}};
            col         <= 8'h00;
        end else begin
            bus.pa      <= act ? pbase + PA_W'(px) : '0;
            bus.ca      <= act ? rbase + CA_W'(cx) : '0;
            frame_start <= (hc == '0) && (vc == '0);
            de_pipe     <= {de_pipe[STAGES-1:0], act};
            hs_pipe     <= {hs_pipe[STAGES-1:0], (hc < HS_END) ? HSYNC_POL : ~HSYNC_POL};
            vs_pipe     <= {vs_pipe[STAGES-1:0], (vc < VS_END) ? VSYNC_POL : ~VSYNC_POL};
            col         <= de_pipe[STAGES-1] ? pix : 8'h00;
        end
    end

    assign bus.vga_de    = de_pipe[STAGES];
    assign bus.vga_hsync = hs_pipe[STAGES];
    assign bus.vga_vsync = vs_pipe[STAGES];
    assign bus.vga_red   = col[7:5];
    assign bus.vga_grn   = col[4:2];
    assign bus.vga_blu   = col[1:0];
endmodule

// File: tb/tb_vga_text_timing.sv
// Directed bench: reduced 27x17 timing instance (5x4 grid of 4x3 cells, FETCH_LAT=2)
// plus a default-parameter instance for reset and sync widths.
module tb_vga_text_timing;
    localparam int HT = 27, VT = 17, FT = HT*VT;
    localparam int HA0 = 5, VA0 = 4, HA = 20, VA = 12;
    localparam int CW = 4, CH = 3, NC = 5, LAT = 2;

    typedef struct packed {
        logic       fs;
        logic [3:0] pa;
        logic [4:0] ca;
        logic       hs;
        logic       vs;
        logic       de;
        logic [7:0] col;
    } obs_t;

    localparam obs_t RST_OBS = '{fs:1'b0, pa:4'd0, ca:5'd0, hs:1'b0, vs:1'b1, de:1'b0, col:8'h00};

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       fs, fsd;
    int         checks = 0;
    int         fails = 0;
    int         k = -1;
    bit         pm = 1'b0;
    logic [7:0] pconst = 8'h00;
    logic [7:0] ph [0:7];

    always #5 clk = ~clk;

    vga_text_timing_if #(.PA_W(4), .CA_W(5))  bus ();
    vga_text_timing_if #(.PA_W(7), .CA_W(11)) busd ();

`ifdef VGA_CURSOR_EN
    logic [2:0] cur_x = 3'd3;
    logic [1:0] cur_y = 2'd2;
    logic       cur_on = 1'b1;
`endif

    vga_text_timing #(
        .H_ACTIVE(20), .H_FP(2), .H_SYNC(3), .H_BP(2),
        .V_ACTIVE(12), .V_FP(1), .V_SYNC(2), .V_BP(2),
        .HSYNC_POL(1'b1), .VSYNC_POL(1'b0),
        .CHAR_W(4), .CHAR_H(3), .COLS(5), .ROWS(4),
        .FETCH_LAT(2), .BLINK_FRAMES(2)
    ) dut (
        .vga_clk(clk), .vga_rst_n(rst_n), .bus(bus), .frame_start(fs)
`ifdef VGA_CURSOR_EN
        , .cursor_x(cur_x), .cursor_y(cur_y), .cursor_on(cur_on)
`endif
    );

    vga_text_timing dutd (
        .vga_clk(clk), .vga_rst_n(rst_n), .bus(busd), .frame_start(fsd)
`ifdef VGA_CURSOR_EN
        , .cursor_x(7'd0), .cursor_y(5'd0), .cursor_on(1'b0)
`endif
    );

    function automatic bit in_act(int pos);
        int h = pos % HT;
        int v = pos / HT;
        return (h >= HA0) && (h < HA0 + HA) && (v >= VA0) && (v < VA0 + VA);
    endfunction

    function automatic int cell_pa(int pos);
        if (!in_act(pos)) return 0;
        return (((pos / HT) - VA0) % CH) * CW + ((pos % HT) - HA0) % CW;
    endfunction

    function automatic int cell_ca(int pos);
        if (!in_act(pos)) return 0;
        return (((pos / HT) - VA0) / CH) * NC + ((pos % HT) - HA0) / CW;
    endfunction

    function automatic logic [7:0] enc(int a, int c);
        return 8'(c*37 + a*5 + 1);
    endfunction

    // Expected outputs after edge kk (edge 0 is the first edge after reset release)
    function automatic obs_t model(int kk, bit curs);
        obs_t e;
        int   pos, d, dp;
        pos   = kk % FT;
        e.fs  = (pos == 0);
        e.pa  = 4'(cell_pa(pos));
        e.ca  = 5'(cell_ca(pos));
        e.hs  = 1'b0;
        e.vs  = 1'b1;
        e.de  = 1'b0;
        e.col = 8'h00;
        d = kk - (LAT + 1);
        if (d >= 0) begin
            dp   = d % FT;
            e.hs = (dp % HT) < 3;
            e.vs = !((dp / HT) < 2);
            e.de = in_act(dp);
            if (e.de) begin
                e.col = pm ? pconst : enc(cell_pa(dp), cell_ca(dp));
                if (curs && ((d / FT) / 2) % 2 == 0 && cell_ca(dp) == 2*NC + 3
                    && (((dp / HT) - VA0) % CH) >= CH - 2)
                    e.col = ~e.col;
            end
        end
        return e;
    endfunction

    function automatic obs_t observe();
        return {fs, bus.pa, bus.ca, bus.vga_hsync, bus.vga_vsync, bus.vga_de,
                bus.vga_red, bus.vga_grn, bus.vga_blu};
    endfunction

    // Advance one edge; the memory model answers the address seen LAT edges ago
    task automatic step();
        @(negedge clk);
        k++;
        ph[k % 8] = enc(int'(bus.pa), int'(bus.ca));
        if (pm)            bus.p = pconst;
        else if (k >= LAT) bus.p = ph[(k - LAT) % 8];
        else               bus.p = 8'h00;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        k = -1;
    endtask

    task automatic test_reset();
        obs_t a;
        rst_n = 1'b0;
        bus.p = 8'h00;
        busd.p = 8'h00;
        repeat (2) @(negedge clk);
        a = observe();
        checks++;
        if (a !== RST_OBS) begin
            fails++;
            $display("FAIL reset_small act=%h exp=%h", a, RST_OBS);
        end
        checks++;
        if ({fsd, busd.pa, busd.ca, busd.vga_hsync, busd.vga_vsync, busd.vga_de,
             busd.vga_red, busd.vga_grn, busd.vga_blu} !== {1'b0, 7'd0, 11'd0, 1'b1, 1'b1, 1'b0, 8'd0}) begin
            fails++;
            $display("FAIL reset_default act=%b %h %h %b%b%b", fsd, busd.pa, busd.ca,
                     busd.vga_hsync, busd.vga_vsync, busd.vga_de);
        end
    endtask

    task automatic test_frame();
        obs_t a, e;
        int   de_cnt = 0;
        int   ca_max = 0;
        pm = 1'b0;
        do_reset();
        for (int i = 0; i < FT + LAT + 1; i++) begin
            step();
            a = observe();
            e = model(k, 1'b0);
            checks++;
            if (a !== e) begin
                fails++;
                $display("FAIL frame k=%0d act=%h exp=%h", k, a, e);
            end
            if (bus.vga_de === 1'b1) de_cnt++;
            if (int'(bus.ca) > ca_max) ca_max = int'(bus.ca);
            if (k == VA0*HT + HA0) begin
                checks++;
                if (bus.pa !== 4'd0 || bus.ca !== 5'd0) begin
                    fails++;
                    $display("FAIL first_addr pa=%0d ca=%0d exp 0 0", bus.pa, bus.ca);
                end
            end
            if (k == VA0*HT + HA0 + LAT || k == VA0*HT + HA0 + LAT + 1) begin
                checks++;
                if (bus.vga_de !== (k == VA0*HT + HA0 + LAT + 1)) begin
                    fails++;
                    $display("FAIL de_rise k=%0d de=%b", k, bus.vga_de);
                end
            end
            if (k == 7*HT + 9) begin
                checks++;
                if (bus.ca !== 5'd6 || bus.pa !== 4'd0) begin
                    fails++;
                    $display("FAIL next_cell_row ca=%0d pa=%0d exp 6 0", bus.ca, bus.pa);
                end
            end
            if (k == 15*HT + 24) begin
                checks++;
                if (bus.ca !== 5'd19 || bus.pa !== 4'd11) begin
                    fails++;
                    $display("FAIL last_pixel ca=%0d pa=%0d exp 19 11", bus.ca, bus.pa);
                end
            end
        end
        checks++;
        if (de_cnt !== HA*VA) begin
            fails++;
            $display("FAIL de_count act=%0d exp=%0d", de_cnt, HA*VA);
        end
        checks++;
        if (ca_max !== 19) begin
            fails++;
            $display("FAIL ca_max act=%0d exp=19", ca_max);
        end
    endtask

    task automatic test_const();
        obs_t a, e;
        pm = 1'b1;
        pconst = 8'hFF;
        do_reset();
        for (int i = 0; i < FT + LAT + 1; i++) begin
            step();
            a = observe();
            e = model(k, 1'b0);
            checks++;
            if (a !== e) begin
                fails++;
                $display("FAIL const k=%0d act=%h exp=%h", k, a, e);
            end
            checks++;
            if ({bus.vga_red, bus.vga_grn, bus.vga_blu} !== (bus.vga_de ? 8'hFF : 8'h00)) begin
                fails++;
                $display("FAIL const_gate k=%0d de=%b rgb=%0d/%0d/%0d", k, bus.vga_de,
                         bus.vga_red, bus.vga_grn, bus.vga_blu);
            end
        end
    endtask

    task automatic test_async_reset();
        obs_t a, e;
        int   guard = 0;
        pm = 1'b0;
        do_reset();
        while (k != 6*HT + 15 && guard < FT) begin
            step();
            guard++;
        end
        checks++;
        if (k != 6*HT + 15 || bus.vga_de !== 1'b1) begin
            fails++;
            $display("FAIL async_setup k=%0d de=%b exp de=1", k, bus.vga_de);
        end
        #2 rst_n = 1'b0;
        #1 a = observe();
        checks++;
        if (a !== RST_OBS) begin
            fails++;
            $display("FAIL async_reset act=%h exp=%h", a, RST_OBS);
        end
        @(negedge clk);
        rst_n = 1'b1;
        k = -1;
        for (int i = 0; i < FT + LAT + 1; i++) begin
            step();
            a = observe();
            e = model(k, 1'b0);
            checks++;
            if (a !== e) begin
                fails++;
                $display("FAIL restart k=%0d act=%h exp=%h", k, a, e);
            end
        end
    endtask

`ifdef VGA_CURSOR_EN
    task automatic test_cursor();
        obs_t a, e;
        int   lit [4] = '{0, 0, 0, 0};
        pm = 1'b1;
        pconst = 8'h00;
        do_reset();
        for (int i = 0; i < 4*FT + LAT + 1; i++) begin
            step();
            a = observe();
            e = model(k, 1'b1);
            checks++;
            if (a !== e) begin
                fails++;
                $display("FAIL cursor k=%0d act=%h exp=%h", k, a, e);
            end
            if (k >= LAT + 1 && a.col == 8'hFF) lit[(k - LAT - 1) / FT]++;
        end
        for (int f = 0; f < 4; f++) begin
            checks++;
            if (lit[f] !== ((f < 2) ? 2*CW : 0)) begin
                fails++;
                $display("FAIL cursor_frame%0d lit=%0d exp=%0d", f, lit[f], (f < 2) ? 2*CW : 0);
            end
        end
    endtask
`endif

    task automatic test_defaults();
        int hs_low = 0;
        int vs_low = 0;
        do_reset();
        for (int i = 0; i < 1610; i++) begin
            step();
            checks++;
            if (fsd !== (k == 0)) begin
                fails++;
                $display("FAIL dflt_frame_start k=%0d act=%b", k, fsd);
            end
            checks++;
            if (busd.vga_de !== 1'b0 || busd.pa !== 7'd0 || busd.ca !== 11'd0) begin
                fails++;
                $display("FAIL dflt_blank k=%0d de=%b pa=%0d ca=%0d", k, busd.vga_de, busd.pa, busd.ca);
            end
            if (k <= 801 && busd.vga_hsync === 1'b0) hs_low++;
            if (busd.vga_vsync === 1'b0) vs_low++;
        end
        checks++;
        if (hs_low !== 96) begin
            fails++;
            $display("FAIL dflt_hsync_width act=%0d exp=96", hs_low);
        end
        checks++;
        if (vs_low !== 1600) begin
            fails++;
            $display("FAIL dflt_vsync_width act=%0d exp=1600", vs_low);
        end
    endtask

    initial begin
        test_reset();
        test_frame();
        test_const();
        test_async_reset();
`ifdef VGA_CURSOR_EN
        test_cursor();
`endif
        test_defaults();
        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end
endmodule
